// File: rtl/multi_angle_sampler.sv
// multi_angle_sampler: polls up to NUM_CH absolute encoders through one shared
// slow-clock reader in enabled-channel round-robin order. It captures each
// channel's raw angle, flags encoders that stop answering, and publishes a
// registered wrap-aware error (target - current) per channel.
module multi_angle_sampler #(
    parameter int NUM_CH         = 4,
    parameter int ANGLE_W        = 12,
    parameter int DIV_W          = 7,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 40000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           ch_mask,
    input  logic                        clear_err,
    input  logic [NUM_CH*ANGLE_W-1:0]   target_angle,
    output logic                        i2c_clk,
    output logic                        rd_req,
    output logic [CH_W-1:0]             rd_ch,
    input  logic                        rd_done,
    input  logic [ANGLE_W-1:0]          raw_angle,
    output logic [NUM_CH*ANGLE_W-1:0]   current_angle,
    output logic [NUM_CH*ANGLE_W-1:0]   angle_error,
    output logic [NUM_CH-1:0]           angle_valid,
    output logic [NUM_CH-1:0]           timeout_err,
    output logic                        sample_strobe,
    output logic [CH_W-1:0]             sample_ch
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, REQ, WAIT, RELEASE} state_t;

    state_t                      state_q, state_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [SYNC_STAGES-1:0]      sync_q, sync_d;
    logic                        done_prev_q, done_prev_d;
    logic [CH_W-1:0]             rd_ch_q, rd_ch_d;
    logic [CH_W-1:0]             last_q, last_d;
    logic [TO_W-1:0]             cnt_q, cnt_d;
    logic [NUM_CH*ANGLE_W-1:0]   cur_q, cur_d;
    logic [NUM_CH*ANGLE_W-1:0]   err_q, err_d;
    logic [NUM_CH-1:0]           valid_q, valid_d;
    logic [NUM_CH-1:0]           terr_q, terr_d;
    logic                        strobe_q, strobe_d;
    logic [CH_W-1:0]             sample_ch_q, sample_ch_d;

    logic                        done_s;
    logic                        done_rise;
    logic [CH_W:0]               start_off;
    logic [NUM_CH-1:0]           rot_mask;
    logic                        found;
    int                          pick_sum;
    logic [CH_W-1:0]             pick;

    assign done_s    = sync_q[SYNC_STAGES-1];
    assign done_rise = done_s & ~done_prev_q;

    // Free-running divider and rd_done synchroniser chain with edge history.
    always_comb begin
        div_d       = div_q + DIV_W'(1);
        sync_d      = {sync_q[SYNC_STAGES-2:0], rd_done};
        done_prev_d = done_s;
    end

    // Rotate the mask so bit 0 is the channel after the last serviced one, then take the first set bit.
    always_comb begin
        start_off = {1'b0, last_q} + (CH_W+1)'(1);
        rot_mask  = NUM_CH'({ch_mask, ch_mask} >> start_off);
        found     = 1'b0;
        pick_sum  = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && rot_mask[j]) begin
                found    = 1'b1;
                pick_sum = int'(last_q) + 1 + j;
            end
        end
        if (pick_sum >= NUM_CH) begin
            pick_sum = pick_sum - NUM_CH;
        end
        pick = CH_W'(pick_sum);
    end

    // Polling FSM: select channel, request, wait for capture or timeout, wait for done to fall.
    always_comb begin
        state_d     = state_q;
        rd_ch_d     = rd_ch_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        valid_d     = valid_q;
        terr_d      = clear_err ? '0 : terr_q;
        strobe_d    = 1'b0;
        sample_ch_d = sample_ch_q;
        case (state_q)
            IDLE: begin
                if (enable && |ch_mask) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (found) begin
                    rd_ch_d = pick;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + TO_W'(1);
                if (done_rise) begin
                    cur_d[rd_ch_q*ANGLE_W +: ANGLE_W] = raw_angle;
                    valid_d[rd_ch_q] = 1'b1;
                    strobe_d         = 1'b1;
                    sample_ch_d      = rd_ch_q;
                    state_d          = RELEASE;
                end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    terr_d[rd_ch_q]  = 1'b1;
                    valid_d[rd_ch_q] = 1'b0;
                    state_d          = RELEASE;
                end
            end
            RELEASE: begin
                if (!done_s) begin
                    last_d  = rd_ch_q;
                    state_d = enable ? SELECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Wrap-aware error: modular difference read as two's complement.
    always_comb begin
        err_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            err_d[i*ANGLE_W +: ANGLE_W] = target_angle[i*ANGLE_W +: ANGLE_W] - cur_q[i*ANGLE_W +: ANGLE_W];
        end
    end

    // State register; reset parks the pointer on the last channel so ch0 is polled first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            sync_q      <= '0;
            done_prev_q <= 1'b0;
            rd_ch_q     <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            cnt_q       <= '0;
            cur_q       <= '0;
            err_q       <= '0;
            valid_q     <= '0;
            terr_q      <= '0;
            strobe_q    <= 1'b0;
            sample_ch_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sync_q      <= sync_d;
            done_prev_q <= done_prev_d;
            rd_ch_q     <= rd_ch_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            terr_q      <= terr_d;
            strobe_q    <= strobe_d;
            sample_ch_q <= sample_ch_d;
        end
    end

    assign i2c_clk       = div_q[DIV_W-1];
    assign rd_req        = (state_q == REQ) || (state_q == WAIT);
    assign rd_ch         = rd_ch_q;
    assign current_angle = cur_q;
    assign angle_error   = err_q;
    assign angle_valid   = valid_q;
    assign timeout_err   = terr_q;
    assign sample_strobe = strobe_q;
    assign sample_ch     = sample_ch_q;

endmodule

// File: tb/tb_multi_angle_sampler.sv
// tb_multi_angle_sampler: randomized scenarios for the multi-channel encoder
// sampler, with a behavioural reader model and a round-robin/arithmetic
// reference kept in the bench.
module tb_multi_angle_sampler;

    localparam int NCH = 4;
    localparam int AW  = 12;
    localparam int DW  = 4;
    localparam int SS  = 2;
    localparam int TO  = 300;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic               clear_err = 1'b0;
    logic [NCH-1:0]     ch_mask = '0;
    logic [NCH*AW-1:0]  target_angle = '0;
    logic               rd_done;
    logic [AW-1:0]      raw_angle;
    logic               i2c_clk;
    logic               rd_req;
    logic [1:0]         rd_ch;
    logic [NCH*AW-1:0]  current_angle;
    logic [NCH*AW-1:0]  angle_error;
    logic [NCH-1:0]     angle_valid;
    logic [NCH-1:0]     timeout_err;
    logic               sample_strobe;
    logic [1:0]         sample_ch;

    int tests = 0;
    int fails = 0;

    // Reader model controls: 0 = answers after 3 i2c_clk periods, 1 = silent, 2 = answers after dly cycles.
    int val  [NCH];
    int mode [NCH];
    int dly  [NCH];

    always #5 clock = ~clock;

    multi_angle_sampler #(
        .NUM_CH(NCH), .ANGLE_W(AW), .DIV_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .clear_err(clear_err), .target_angle(target_angle), .i2c_clk(i2c_clk),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_done(rd_done), .raw_angle(raw_angle),
        .current_angle(current_angle), .angle_error(angle_error),
        .angle_valid(angle_valid), .timeout_err(timeout_err),
        .sample_strobe(sample_strobe), .sample_ch(sample_ch)
    );

    // Behavioural shared reader: answers a level request, holds done until the request drops.
    initial begin : reader
        int ch;
        int n;
        logic prev;
        rd_done   = 1'b0;
        raw_angle = '0;
        forever begin
            @(posedge clock); #1;
            if (rd_req !== 1'b1) continue;
            ch   = int'(rd_ch);
            n    = 0;
            prev = i2c_clk;
            if (mode[ch] == 1) begin
                while (rd_req === 1'b1) begin @(posedge clock); #1; end
                continue;
            end else if (mode[ch] == 2) begin
                while (rd_req === 1'b1 && n < dly[ch]) begin @(posedge clock); #1; n++; end
            end else begin
                while (rd_req === 1'b1 && n < 3) begin
                    @(posedge clock); #1;
                    if (i2c_clk && !prev) n++;
                    prev = i2c_clk;
                end
            end
            if (rd_req === 1'b1) begin
                raw_angle = AW'(val[ch]);
                rd_done   = 1'b1;
                while (rd_req === 1'b1) begin @(posedge clock); #1; end
                rd_done   = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Next polled channel: first enabled channel after 'last', circularly.
    function automatic int next_ch(int last, logic [NCH-1:0] m);
        int mi;
        mi = int'(m);
        for (int k = 1; k <= NCH; k++) begin
            if (((mi >> ((last + k) % NCH)) & 1) == 1) return (last + k) % NCH;
        end
        return -1;
    endfunction

    // Shortest signed path from current to target on a 2^AW circle, half turn reads negative.
    function automatic int wrap_err(int t, int c);
        int d;
        d = (t - c) % 4096;
        if (d < 0) d = d + 4096;
        if (d >= 2048) d = d - 4096;
        return d;
    endfunction

    function automatic int cur_of(int ch);
        return int'(current_angle[ch*AW +: AW]);
    endfunction

    function automatic int err_of(int ch);
        return int'($signed(angle_error[ch*AW +: AW]));
    endfunction

    task automatic set_target(input int ch, input int t);
        target_angle[ch*AW +: AW] = AW'(t);
    endtask

    task automatic do_reset;
        reset = 1'b1; enable = 1'b0; ch_mask = '0; clear_err = 1'b0;
        for (int c = 0; c < NCH; c++) begin mode[c] = 0; dly[c] = 0; val[c] = 0; end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_strobe(input int budget, input string what, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (sample_strobe === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("[TB] FAIL %s: no sample_strobe within %0d cycles, expected one", what, budget);
        end
    endtask

    task automatic wait_req(input int budget, input string what, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (rd_req === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("[TB] FAIL %s: rd_req stayed low for %0d cycles, expected high", what, budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if ({rd_req, sample_strobe, i2c_clk} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {rd_req, sample_strobe, i2c_clk});
        end
        tests++;
        if (current_angle !== '0 || angle_error !== '0) begin
            fails++; $display("[TB] FAIL reset_angles: got cur=%h err=%h expected 0", current_angle, angle_error);
        end
        tests++;
        if (angle_valid !== '0 || timeout_err !== '0 || rd_ch !== '0 || sample_ch !== '0) begin
            fails++; $display("[TB] FAIL reset_flags: got valid=%b terr=%b rd_ch=%0d sch=%0d expected 0",
                              angle_valid, timeout_err, rd_ch, sample_ch);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin;
        int last, exp;
        bit ok;
        do_reset;
        for (int c = 0; c < NCH; c++) val[c] = 100 + c;
        ch_mask = 4'b1011; enable = 1'b1; last = NCH - 1;
        for (int n = 0; n < 8; n++) begin
            exp = next_ch(last, ch_mask);
            wait_strobe(400, "rr_strobe", ok);
            if (!ok) return;
            tests++;
            if (int'(sample_ch) != exp) begin
                fails++; $display("[TB] FAIL rr_order: got ch %0d expected %0d", sample_ch, exp);
            end
            tests++;
            if (cur_of(exp) != val[exp] || angle_valid[exp] !== 1'b1) begin
                fails++; $display("[TB] FAIL rr_capture: got %0d valid %b expected %0d valid 1",
                                  cur_of(exp), angle_valid[exp], val[exp]);
            end
            tests++;
            if (rd_req !== 1'b0) begin
                fails++; $display("[TB] FAIL rr_req_low: got rd_req %b expected 0", rd_req);
            end
            @(negedge clock);
            tests++;
            if (sample_strobe !== 1'b0) begin
                fails++; $display("[TB] FAIL rr_strobe_width: got %b expected 0", sample_strobe);
            end
            if (n >= 3) val[exp] = $urandom_range(0, 4095);
            last = exp;
        end
        tests++;
        if (cur_of(2) != 0 || angle_valid[2] !== 1'b0) begin
            fails++; $display("[TB] FAIL rr_masked_ch: got %0d valid %b expected 0 valid 0", cur_of(2), angle_valid[2]);
        end
        enable = 1'b0;
    endtask

    task automatic test_random_masks;
        int last, exp;
        int tgt [NCH];
        bit ok;
        do_reset;
        for (int c = 0; c < NCH; c++) begin
            tgt[c] = $urandom_range(0, 4095);
            set_target(c, tgt[c]);
            val[c] = $urandom_range(0, 4095);
        end
        ch_mask = NCH'($urandom_range(1, 15)); enable = 1'b1; last = NCH - 1;
        for (int it = 0; it < 3; it++) begin
            for (int n = 0; n < 4; n++) begin
                exp = next_ch(last, ch_mask);
                wait_strobe(400, "rand_strobe", ok);
                if (!ok) return;
                tests++;
                if (int'(sample_ch) != exp || cur_of(exp) != val[exp]) begin
                    fails++; $display("[TB] FAIL rand_capture: got ch %0d angle %0d expected ch %0d angle %0d",
                                      sample_ch, cur_of(exp), exp, val[exp]);
                end
                @(negedge clock);
                tests++;
                if (err_of(exp) != wrap_err(tgt[exp], val[exp])) begin
                    fails++; $display("[TB] FAIL rand_error: got %0d expected %0d", err_of(exp), wrap_err(tgt[exp], val[exp]));
                end
                val[exp] = $urandom_range(0, 4095);
                last = exp;
                if (n == 3) ch_mask = NCH'($urandom_range(1, 15));
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_wrap_error;
        bit ok;
        do_reset;
        ch_mask = 4'b0001; set_target(0, 10); val[0] = 4090; enable = 1'b1;
        wait_strobe(400, "wrap_strobe1", ok);
        if (!ok) return;
        @(negedge clock);
        tests++;
        if (err_of(0) != 16) begin
            fails++; $display("[TB] FAIL wrap_pos: got %0d expected 16", err_of(0));
        end
        val[0] = 10;
        wait_strobe(400, "wrap_strobe2", ok);
        if (!ok) return;
        set_target(0, 4090);
        @(negedge clock);
        tests++;
        if (err_of(0) != -16) begin
            fails++; $display("[TB] FAIL wrap_neg_latency: got %0d expected -16", err_of(0));
        end
        val[0] = 0;
        wait_strobe(400, "wrap_strobe3", ok);
        if (!ok) return;
        set_target(0, 2048);
        @(negedge clock);
        tests++;
        if (err_of(0) != -2048) begin
            fails++; $display("[TB] FAIL wrap_half: got %0d expected -2048", err_of(0));
        end
        enable = 1'b0;
    endtask

    task automatic test_timeout;
        bit ok;
        bit seen;
        do_reset;
        val[2] = $urandom_range(0, 4095); val[3] = $urandom_range(0, 4095);
        ch_mask = 4'b1100; enable = 1'b1;
        wait_strobe(400, "to_first_ch2", ok);
        if (!ok) return;
        wait_strobe(400, "to_first_ch3", ok);
        if (!ok) return;
        mode[2] = 1;
        seen = 1'b0;
        for (int i = 0; i < TO + 200 && !seen; i++) begin
            @(negedge clock);
            if (timeout_err[2] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || timeout_err !== 4'b0100 || angle_valid[2] !== 1'b0) begin
            fails++; $display("[TB] FAIL to_flag: got terr %b valid2 %b expected terr 0100 valid2 0",
                              timeout_err, angle_valid[2]);
        end
        wait_strobe(400, "to_next_ch3", ok);
        if (!ok) return;
        tests++;
        if (int'(sample_ch) != 3) begin
            fails++; $display("[TB] FAIL to_moves_on: got ch %0d expected 3", sample_ch);
        end
        mode[2] = 0; val[2] = $urandom_range(0, 4095);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        tests++;
        if (timeout_err !== 4'b0000) begin
            fails++; $display("[TB] FAIL to_clear: got %b expected 0000", timeout_err);
        end
        wait_strobe(400, "to_recover", ok);
        if (!ok) return;
        tests++;
        if (int'(sample_ch) != 2 || angle_valid[2] !== 1'b1 || cur_of(2) != val[2] || timeout_err[2] !== 1'b0) begin
            fails++; $display("[TB] FAIL to_recover: got ch %0d valid %b angle %0d expected ch 2 valid 1 angle %0d",
                              sample_ch, angle_valid[2], cur_of(2), val[2]);
        end
        enable = 1'b0;
    endtask

    task automatic test_race;
        bit ok;
        bit seen;
        bit saw_strobe;
        int first;
        do_reset;
        mode[0] = 2; dly[0] = TO - 2; val[0] = $urandom_range(0, 4095);
        ch_mask = 4'b0001; enable = 1'b1;
        wait_strobe(TO + 100, "race_edge", ok);
        if (!ok) return;
        tests++;
        if (cur_of(0) != val[0] || timeout_err !== 4'b0000 || angle_valid[0] !== 1'b1) begin
            fails++; $display("[TB] FAIL race_capture_wins: got angle %0d terr %b expected angle %0d terr 0000",
                              cur_of(0), timeout_err, val[0]);
        end
        first = val[0];
        dly[0] = TO - 1;
        val[0] = (first + 1 + $urandom_range(0, 4000)) % 4096;
        seen = 1'b0; saw_strobe = 1'b0;
        for (int i = 0; i < TO + 200 && !seen; i++) begin
            @(negedge clock);
            if (sample_strobe === 1'b1) saw_strobe = 1'b1;
            if (timeout_err[0] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || saw_strobe || cur_of(0) != first || angle_valid[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL race_late_timeout: got terr %b strobe %b angle %0d valid %b expected terr 1 strobe 0 angle %0d valid 0",
                              timeout_err[0], saw_strobe, cur_of(0), angle_valid[0], first);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop;
        bit ok;
        int highs;
        do_reset;
        for (int c = 0; c < NCH; c++) val[c] = $urandom_range(0, 4095);
        ch_mask = 4'b1111; enable = 1'b1;
        wait_req(20, "en_req", ok);
        if (!ok) return;
        @(negedge clock);
        enable = 1'b0;
        wait_strobe(400, "en_complete", ok);
        if (!ok) return;
        tests++;
        if (int'(sample_ch) != 0 || cur_of(0) != val[0]) begin
            fails++; $display("[TB] FAIL en_complete: got ch %0d angle %0d expected ch 0 angle %0d", sample_ch, cur_of(0), val[0]);
        end
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (rd_req !== 1'b0) highs++;
        end
        tests++;
        if (highs != 0) begin
            fails++; $display("[TB] FAIL en_idle: got %0d request cycles expected 0", highs);
        end
        enable = 1'b1;
        wait_req(20, "en_resume", ok);
        if (!ok) return;
        tests++;
        if (int'(rd_ch) != 1) begin
            fails++; $display("[TB] FAIL en_resume_ch: got %0d expected 1", rd_ch);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        bit ok;
        do_reset;
        for (int c = 0; c < NCH; c++) val[c] = $urandom_range(1, 4095);
        ch_mask = 4'b1111; enable = 1'b1;
        wait_strobe(400, "rst_cap0", ok);
        if (!ok) return;
        wait_strobe(400, "rst_cap1", ok);
        if (!ok) return;
        wait_req(20, "rst_req2", ok);
        if (!ok) return;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (rd_req !== 1'b0 || i2c_clk !== 1'b0 || angle_valid !== '0 || current_angle !== '0 || timeout_err !== '0) begin
            fails++; $display("[TB] FAIL rst_async: got req %b clk %b valid %b cur %h expected all 0",
                              rd_req, i2c_clk, angle_valid, current_angle);
        end
        @(negedge clock);
        reset = 1'b0;
        wait_req(20, "rst_restart", ok);
        if (!ok) return;
        tests++;
        if (int'(rd_ch) != 0) begin
            fails++; $display("[TB] FAIL rst_first_ch: got %0d expected 0", rd_ch);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_random_masks;
        test_wrap_error;
        test_timeout;
        test_race;
        test_enable_drop;
        test_reset_mid_wait;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_angle_sampler.md
Name: multi_angle_sampler

Overview:
- Generalised successor to the single-encoder angle capture in the PWM control path.
- Polls up to NUM_CH absolute encoders through one shared slow-clock I2C reader, using enabled-channel round-robin order.
- Synchronises the reader's done flag and captures each channel's raw angle.
- Flags non-responding encoders by timeout and publishes a registered, wrap-aware shortest-path error per channel for the angle-to-PWM stage.

Parameters:
NUM_CH, 4, number of encoder channels (1..8)
ANGLE_W, 12, encoder angle width in bits
DIV_W, 7, divider width; i2c_clk period = 2^DIV_W clock cycles
SYNC_STAGES, 2, flops in rd_done synchroniser (>=2)
TIMEOUT_CYCLES, 40000, clock cycles allowed in WAIT before declaring channel timeout

Ports:
clock  in  1  main clock
reset  in  1  asynchronous reset, active-high
enable  in  1  polling enable
ch_mask  in  NUM_CH  per-channel poll enable
clear_err  in  1  clears all timeout_err bits
target_angle  in  NUM_CH*ANGLE_W  packed targets, ch0 in LSBs
i2c_clk  out  1  divided clock for shared reader (divider MSB)
rd_req  out  1  level request to reader, held until capture or timeout
rd_ch  out  clog2(NUM_CH) (min 1)  channel/mux select for reader
rd_done  in  1  reader done, asynchronous to clock
raw_angle  in  ANGLE_W  reader result, stable while rd_done high
current_angle  out  NUM_CH*ANGLE_W  last captured angle per channel
angle_error  out  NUM_CH*ANGLE_W  signed (target - current) mod 2^ANGLE_W
angle_valid  out  NUM_CH  channel holds a good sample
timeout_err  out  NUM_CH  sticky timeout flag per channel
sample_strobe  out  1  one-cycle pulse on each capture
sample_ch  out  clog2(NUM_CH)  channel of latest capture

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, divider 0, synchroniser 0, last-serviced pointer = NUM_CH-1, so the first poll is ch0.
- Divider: DIV_W-bit free-running up counter; i2c_clk = counter[DIV_W-1]. Wraps naturally.
- rd_done passes through SYNC_STAGES flops to give done_s. A rising edge is done_s high while the previous stage-out was low.
- FSM states: IDLE, SELECT, REQ, WAIT, RELEASE.
- IDLE -> SELECT when enable && |ch_mask.
- SELECT:
  - Picks the first set ch_mask bit after the last-serviced pointer, circularly, and loads rd_ch. Takes 1 cycle.
  - If the mask became 0, returns to IDLE.
- REQ: asserts rd_req, clears the timeout counter, goes to WAIT.
- WAIT: rd_req stays high; the counter increments each cycle.
  - Rising edge of done_s:
    - current_angle[rd_ch] <= raw_angle; angle_valid[rd_ch] <= 1.
    - sample_strobe pulses for 1 cycle; sample_ch <= rd_ch.
    - rd_req drops; go to RELEASE.
  - Counter == TIMEOUT_CYCLES-1 with no edge:
    - timeout_err[rd_ch] <= 1; angle_valid[rd_ch] <= 0.
    - rd_req drops; go to RELEASE.
  - Edge and timeout in the same cycle: the capture wins and no error is set.
- RELEASE:
  - Waits for done_s low, then updates the last-serviced pointer to rd_ch.
  - Goes to SELECT if enable, else IDLE.
- Ordering: rd_req never re-asserts before done_s is observed low.
- enable deasserted mid-transaction: the current transaction completes (capture or timeout), then the FSM goes to IDLE. A ch_mask bit cleared mid-transaction also lets the transaction complete.
- clear_err: clears all timeout_err bits. A timeout set in the same cycle wins for its channel.
- angle_error[i] <= target_angle[i] - current_angle[i], truncated to ANGLE_W bits and read as two's complement. Latency is 1 cycle after either operand changes. Range is -2^(W-1)..2^(W-1)-1; a difference of exactly half a turn reports -2^(W-1).
- Reset asserted mid-transaction: everything returns to reset values immediately and rd_req drops asynchronously.

Test Plan:
- Round-robin: ch_mask=4'b1011, reader model returns 100+ch after 3 i2c_clk periods -> rd_ch sequence 0,1,3,0,…; current_angle = 100,101,-,103; sample_strobe once per capture; rd_req low between captures.
- Wrap-around error: target[0]=10, capture 4090 -> angle_error[0]=16. Target 4090, current 10 -> -16. Target 2048, current 0 -> -2048.
- Timeout: ch2 reader never answers -> after 40000 cycles timeout_err[2]=1 and angle_valid[2]=0, polling moves to ch3. Pulse clear_err -> bit clears; a later good read sets angle_valid[2]=1.
- Race: done_s edge on the final timeout cycle -> capture recorded, timeout_err unchanged.
- enable dropped during WAIT -> that capture still completes, FSM reaches IDLE, no further rd_req until enable=1.
- Reset mid-WAIT -> rd_req, angle_valid, current_angle and i2c_clk all 0 immediately; after release the first poll is ch0.
